// File: rtl/elevator_group_ctrl.sv
// elevator_group_ctrl: single-car collective (SCAN) lift controller.
// Hall and car calls are latched into a pending mask and served in travel
// order; the car reverses only when no work remains ahead of it.
// Optional feature: define ELEV_DOOR_HOLD_EN to add the door_hold_i input.
// The input keeps the door open while it is high.
// The edge that leaves IDLE or DOOR_OPEN also counts as the first travel
// cycle. The first floor is therefore reached TRAVEL_CYC-1 edges after
// departure, and each later floor takes TRAVEL_CYC edges.

module elevator_group_ctrl #(
   parameter int N_FLOORS   = 8,
   parameter int FLOOR_W    = 3,
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 6,
   parameter int HOME_FLOOR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] hall_req_i,
   input  logic [N_FLOORS-1:0] car_req_i,
`ifdef ELEV_DOOR_HOLD_EN
   input  logic                door_hold_i,
`endif
   output logic [FLOOR_W-1:0]  floor_o,
   output logic [1:0]          dir_o,
   output logic                moving_o,
   output logic                door_open_o,
   output logic [N_FLOORS-1:0] pending_o,
   output logic                busy_o
);

   localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
   localparam logic [CNT_W-1:0]   DWELL_LOAD  = CNT_W'(DOOR_CYC);
   localparam logic [CNT_W-1:0]   DEPART_CNT  = (TRAVEL_CYC > 1) ? CNT_W'(1) : CNT_W'(0);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   state_t              state, state_next;
   logic [FLOOR_W-1:0]  floor, floor_next, step_floor;
   logic                pref_up, pref_up_next;
   logic [CNT_W-1:0]    travel_cnt, travel_cnt_next;
   logic [CNT_W-1:0]    dwell_cnt, dwell_cnt_next;
   logic [N_FLOORS-1:0] pending, clear_mask;
   logic [N_FLOORS-1:0] here_mask, step_mask, up_mask, down_mask;
   logic                here_pending, step_pending, ahead_up, ahead_down;
   logic                same_ahead, behind, at_end, hold;

`ifdef ELEV_DOOR_HOLD_EN
   assign hold = door_hold_i;
`else
   assign hold = 1'b0;
`endif

   // Decode the current and next floor into masks, plus the above/below regions
   always_comb begin
      step_floor = (state == MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
      here_mask  = '0;
      step_mask  = '0;
      up_mask    = '0;
      down_mask  = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         here_mask[i] = (int'(floor) == i);
         step_mask[i] = (int'(step_floor) == i);
         up_mask[i]   = (i > int'(floor));
         down_mask[i] = (i < int'(floor));
      end
   end

   assign here_pending = |(pending & here_mask);
   assign step_pending = |(pending & step_mask);
   assign ahead_up     = |(pending & up_mask);
   assign ahead_down   = |(pending & down_mask);
   assign same_ahead   = pref_up ? ahead_up : ahead_down;
   assign behind       = pref_up ? ahead_down : ahead_up;
   assign at_end       = (state == MOVE_UP) ? (step_floor == TOP_FLOOR) : (step_floor == '0);

   // Next-state logic: dispatch from IDLE, floor stepping, and door dwell
   always_comb begin
      state_next      = state;
      floor_next      = floor;
      pref_up_next    = pref_up;
      travel_cnt_next = travel_cnt;
      dwell_cnt_next  = dwell_cnt;
      clear_mask      = '0;
      case (state)
         IDLE: begin
            if (here_pending) begin
               state_next     = DOOR_OPEN;
               clear_mask     = here_mask;
               dwell_cnt_next = DWELL_LOAD;
            end else if (same_ahead) begin
               state_next      = pref_up ? MOVE_UP : MOVE_DOWN;
               travel_cnt_next = DEPART_CNT;
            end else if (behind) begin
               pref_up_next    = ~pref_up;
               state_next      = pref_up ? MOVE_DOWN : MOVE_UP;
               travel_cnt_next = DEPART_CNT;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (travel_cnt == TRAVEL_LAST) begin
               floor_next      = step_floor;
               travel_cnt_next = '0;
               if (step_pending) begin
                  state_next     = DOOR_OPEN;
                  clear_mask     = step_mask;
                  dwell_cnt_next = DWELL_LOAD;
               end else if (at_end) begin
                  state_next = IDLE;
               end
            end else begin
               travel_cnt_next = travel_cnt + CNT_W'(1);
            end
         end
         DOOR_OPEN: begin
            if (here_pending || hold) begin
               clear_mask     = here_mask;
               dwell_cnt_next = DWELL_LOAD;
            end else if (dwell_cnt > CNT_W'(1)) begin
               dwell_cnt_next = dwell_cnt - CNT_W'(1);
            end else begin
               dwell_cnt_next = '0;
               if (same_ahead) begin
                  state_next      = pref_up ? MOVE_UP : MOVE_DOWN;
                  travel_cnt_next = DEPART_CNT;
               end else if (behind) begin
                  pref_up_next    = ~pref_up;
                  state_next      = pref_up ? MOVE_DOWN : MOVE_UP;
                  travel_cnt_next = DEPART_CNT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, position, counters and request latch; a clear beats a new set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         floor      <= FLOOR_W'(HOME_FLOOR);
         pref_up    <= 1'b1;
         travel_cnt <= '0;
         dwell_cnt  <= '0;
         pending    <= '0;
      end else begin
         state      <= state_next;
         floor      <= floor_next;
         pref_up    <= pref_up_next;
         travel_cnt <= travel_cnt_next;
         dwell_cnt  <= dwell_cnt_next;
         pending    <= (pending | hall_req_i | car_req_i) & ~clear_mask;
      end
   end

   assign floor_o     = floor;
   assign moving_o    = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign door_open_o = (state == DOOR_OPEN);
   assign dir_o       = (state == IDLE) ? 2'b00 : (pref_up ? 2'b01 : 2'b10);
   assign pending_o   = pending;
   assign busy_o      = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_elevator_group_ctrl.sv
// Testbench for elevator_group_ctrl.
// The bench runs directed scenarios followed by random calls. On every cycle
// it compares the DUT outputs against a behavioural model of the car. The
// model tracks the remaining travel and door time as plain integers.

module tb_elevator_group_ctrl;

   localparam int N_FLOORS   = 8;
   localparam int FLOOR_W    = 3;
   localparam int TRAVEL_CYC = 4;
   localparam int DOOR_CYC   = 6;
   localparam int HOME_FLOOR = 0;

   logic                clk;
   logic                rst_n;
   logic [N_FLOORS-1:0] hall_req;
   logic [N_FLOORS-1:0] car_req;
`ifdef ELEV_DOOR_HOLD_EN
   logic                door_hold;
`endif
   logic [FLOOR_W-1:0]  floor_o;
   logic [1:0]          dir_o;
   logic                moving_o;
   logic                door_open_o;
   logic [N_FLOORS-1:0] pending_o;
   logic                busy_o;

   int n_vectors     = 0;
   int n_miscompares = 0;

   // Model state: position, travel direction (+1/-1), and remaining door
   // and travel cycles (0 means inactive), plus the outstanding calls
   int m_floor;
   int m_dir;
   int m_door_left;
   int m_travel_left;
   bit m_pend [N_FLOORS];

   logic [7:0] rnd_hall, rnd_car;
   logic       rnd_hold;
   bit         saw_down, saw_stop2, saw_stop6;

   elevator_group_ctrl #(
      .N_FLOORS  (N_FLOORS),
      .FLOOR_W   (FLOOR_W),
      .TRAVEL_CYC(TRAVEL_CYC),
      .DOOR_CYC  (DOOR_CYC),
      .HOME_FLOOR(HOME_FLOOR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hall_req_i (hall_req),
      .car_req_i  (car_req),
`ifdef ELEV_DOOR_HOLD_EN
      .door_hold_i(door_hold),
`endif
      .floor_o    (floor_o),
      .dir_o      (dir_o),
      .moving_o   (moving_o),
      .door_open_o(door_open_o),
      .pending_o  (pending_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_floor       = HOME_FLOOR;
      m_dir         = 1;
      m_door_left   = 0;
      m_travel_left = 0;
      for (int i = 0; i < N_FLOORS; i++) m_pend[i] = 1'b0;
   endtask

   function automatic bit workBeyond(input int d);
      for (int i = 0; i < N_FLOORS; i++)
         if (m_pend[i] && ((d > 0) ? (i > m_floor) : (i < m_floor))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit modelSettled();
      if (m_door_left > 0 || m_travel_left > 0) return 1'b0;
      for (int i = 0; i < N_FLOORS; i++) if (m_pend[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Start a trip: keep the current direction if work lies that way, else reverse
   task automatic modelStartTrip();
      if (workBeyond(m_dir)) begin
         m_travel_left = TRAVEL_CYC - 1;
      end else if (workBeyond(-m_dir)) begin
         m_dir         = -m_dir;
         m_travel_left = TRAVEL_CYC - 1;
      end
   endtask

   // Advance the model by one clock edge using the inputs sampled at that edge
   task automatic modelStep(input logic [7:0] hall, input logic [7:0] car, input logic hold);
      int served;
      served = -1;
      if (m_door_left > 0) begin
         if (m_pend[m_floor] || hold) begin
            served      = m_floor;
            m_door_left = DOOR_CYC;
         end else if (m_door_left == 1) begin
            m_door_left = 0;
            modelStartTrip();
         end else begin
            m_door_left--;
         end
      end else if (m_travel_left > 0) begin
         m_travel_left--;
         if (m_travel_left == 0) begin
            m_floor += m_dir;
            if (m_pend[m_floor]) begin
               served      = m_floor;
               m_door_left = DOOR_CYC;
            end else if (m_floor != 0 && m_floor != N_FLOORS - 1) begin
               m_travel_left = TRAVEL_CYC;
            end
         end
      end else begin
         if (m_pend[m_floor]) begin
            served      = m_floor;
            m_door_left = DOOR_CYC;
         end else begin
            modelStartTrip();
         end
      end
      for (int i = 0; i < N_FLOORS; i++)
         m_pend[i] = (m_pend[i] | hall[i] | car[i]) & (i != served);
   endtask

   task automatic compareAll();
      logic [7:0] exp_pend;
      bit         idle;
      int         exp_dir;
      for (int i = 0; i < N_FLOORS; i++) exp_pend[i] = m_pend[i];
      idle    = (m_door_left == 0) && (m_travel_left == 0);
      exp_dir = idle ? 0 : ((m_dir > 0) ? 1 : 2);
      checkOutput("floor",   32'(floor_o), m_floor);
      checkOutput("dir",     32'(dir_o), exp_dir);
      checkOutput("moving",  32'(moving_o), 32'(m_travel_left > 0));
      checkOutput("door",    32'(door_open_o), 32'(m_door_left > 0));
      checkOutput("pending", 32'(pending_o), 32'(exp_pend));
      checkOutput("busy",    32'(busy_o), 32'(!idle || exp_pend != 8'h00));
      checkOutput("door_vs_moving", 32'(door_open_o & moving_o), 0);
   endtask

   task automatic applyStimulus(input logic [7:0] hall, input logic [7:0] car, input logic hold);
      hall_req = hall;
      car_req  = car;
`ifdef ELEV_DOOR_HOLD_EN
      door_hold = hold;
`endif
      @(posedge clk);
      modelStep(hall, car, hold);
      #1;
      compareAll();
   endtask

   task automatic waitSettled(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (modelSettled()) break;
         applyStimulus(8'h00, 8'h00, 1'b0);
      end
      checkOutput("settle_busy", 32'(busy_o), 0);
   endtask

   task automatic waitFloor(input int f, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (m_floor == f) break;
         applyStimulus(8'h00, 8'h00, 1'b0);
      end
      checkOutput("reach_floor", 32'(floor_o), f);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_floor",   32'(floor_o), HOME_FLOOR);
      checkOutput("rst_dir",     32'(dir_o), 0);
      checkOutput("rst_moving",  32'(moving_o), 0);
      checkOutput("rst_door",    32'(door_open_o), 0);
      checkOutput("rst_pending", 32'(pending_o), 0);
      checkOutput("rst_busy",    32'(busy_o), 0);
   endtask

   initial begin
      hall_req = '0;
      car_req  = '0;
`ifdef ELEV_DOOR_HOLD_EN
      door_hold = 1'b0;
`endif
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkResetValues();
      rst_n = 1'b1;
      repeat (2) applyStimulus(8'h00, 8'h00, 1'b0);

      // Single car call from floor 0 to floor 3
      applyStimulus(8'h00, 8'h08, 1'b0);
      for (int j = 1; j <= 18; j++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         if (j == 1)  checkOutput("t1_depart", 32'(moving_o), 1);
         if (j == 3)  checkOutput("t1_floor_k3", 32'(floor_o), 0);
         if (j == 4)  checkOutput("t1_floor_k4", 32'(floor_o), 1);
         if (j == 8)  checkOutput("t1_floor_k8", 32'(floor_o), 2);
         if (j == 12) begin
            checkOutput("t1_floor_k12", 32'(floor_o), 3);
            checkOutput("t1_door_k12", 32'(door_open_o), 1);
            checkOutput("t1_pend3_k12", 32'(pending_o[3]), 0);
         end
         if (j == 17) checkOutput("t1_door_k17", 32'(door_open_o), 1);
         if (j == 18) begin
            checkOutput("t1_door_k18", 32'(door_open_o), 0);
            checkOutput("t1_dir_k18", 32'(dir_o), 0);
            checkOutput("t1_busy_k18", 32'(busy_o), 0);
         end
      end

      // Return to floor 0; then hall 5 and car 2 arrive in the same cycle
      applyStimulus(8'h00, 8'h01, 1'b0);
      waitSettled(100);
      saw_down  = 1'b0;
      saw_stop2 = 1'b0;
      applyStimulus(8'h20, 8'h04, 1'b0);
      for (int j = 0; j < 60; j++) begin
         if (modelSettled()) break;
         applyStimulus(8'h00, 8'h00, 1'b0);
         if (dir_o == 2'b10) saw_down = 1'b1;
         if (door_open_o && floor_o == 3'd2) saw_stop2 = 1'b1;
      end
      checkOutput("t2_no_down", 32'(saw_down), 0);
      checkOutput("t2_stop_at_2", 32'(saw_stop2), 1);
      checkOutput("t2_end_floor", 32'(floor_o), 5);

      // Move to floor 4; test a same-floor call, then a lost set and a dwell restart
      applyStimulus(8'h00, 8'h10, 1'b0);
      waitSettled(100);
      applyStimulus(8'h00, 8'h10, 1'b0);
      applyStimulus(8'h00, 8'h10, 1'b0);
      checkOutput("t4_door_k1", 32'(door_open_o), 1);
      checkOutput("t4_floor_k1", 32'(floor_o), 4);
      checkOutput("t4_clear_wins", 32'(pending_o), 0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h10, 1'b0);
      for (int j = 4; j <= 10; j++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         checkOutput("t4_no_move", 32'(moving_o), 0);
         if (j == 9)  checkOutput("t4_door_k9", 32'(door_open_o), 1);
         if (j == 10) checkOutput("t4_door_k10", 32'(door_open_o), 0);
      end

      // From floor 0 head for 6; a hall call for floor 1 is raised at floor 2
      applyStimulus(8'h00, 8'h01, 1'b0);
      waitSettled(100);
      applyStimulus(8'h00, 8'h40, 1'b0);
      waitFloor(2, 50);
      applyStimulus(8'h02, 8'h00, 1'b0);
      saw_stop6 = 1'b0;
      for (int j = 0; j < 150; j++) begin
         if (modelSettled()) break;
         applyStimulus(8'h00, 8'h00, 1'b0);
         if (door_open_o && floor_o == 3'd6) saw_stop6 = 1'b1;
      end
      checkOutput("t3_served_6", 32'(saw_stop6), 1);
      checkOutput("t3_end_floor", 32'(floor_o), 1);
      checkOutput("t3_end_pending", 32'(pending_o), 0);

      // Asynchronous reset while travelling between floors 2 and 3
      applyStimulus(8'h20, 8'h80, 1'b0);
      waitFloor(2, 50);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("rst_pre_pending", 32'(pending_o), 32'h0000_00A0);
      checkOutput("rst_pre_moving", 32'(moving_o), 1);
      #2 rst_n = 1'b0;
      #1 checkResetValues();
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h00, 8'h00, 1'b0);

`ifdef ELEV_DOOR_HOLD_EN
      // Hold the door for 20 cycles; it then closes after a full dwell
      applyStimulus(8'h00, 8'h01, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      for (int j = 0; j < 20; j++) begin
         applyStimulus(8'h00, 8'h00, 1'b1);
         checkOutput("hold_door", 32'(door_open_o), 1);
      end
      for (int j = 1; j <= 6; j++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         if (j == 5) checkOutput("hold_rel5", 32'(door_open_o), 1);
         if (j == 6) checkOutput("hold_rel6", 32'(door_open_o), 0);
      end
`endif

      // Random calls against the model
      for (int j = 0; j < 500; j++) begin
         rnd_hall = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         rnd_car  = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
`ifdef ELEV_DOOR_HOLD_EN
         rnd_hold = ($urandom_range(0, 9) == 0);
`else
         rnd_hold = 1'b0;
`endif
         applyStimulus(rnd_hall, rnd_car, rnd_hold);
      end
      waitSettled(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/elevator_group_ctrl.md
Name: elevator_group_ctrl

Overview:
- Parametrised successor to the single-car lift controller: one car serving N_FLOORS floors with a collective (SCAN) algorithm.
- Hall and car requests are latched into a pending mask and served in travel order; the car reverses only when nothing is pending ahead.
- Per-floor travel time and door dwell are timed by counters; floor, direction, door and busy status are exported to the display/top level.

Parameters:
- N_FLOORS, 8, number of floors (2..16); floors numbered 0..N_FLOORS-1.
- FLOOR_W, 3, width of floor index; must satisfy 2**FLOOR_W >= N_FLOORS.
- TRAVEL_CYC, 4, clock cycles to travel one floor (>=1).
- DOOR_CYC, 6, clock cycles the door stays open (>=1).
- HOME_FLOOR, 0, floor the car sits at after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- hall_req_i  in  N_FLOORS  one-hot-or-more call pulses from floor panels, bit f = floor f
- car_req_i  in  N_FLOORS  destination button pulses from the car panel
- floor_o  out  FLOOR_W  current car floor
- dir_o  out  2  01 = up, 10 = down, 00 = none
- moving_o  out  1  car between floors
- door_open_o  out  1  door open
- pending_o  out  N_FLOORS  latched outstanding requests
- busy_o  out  1  high when state != IDLE or pending_o != 0

Behaviour:
- Reset: as decided, reset rst_n, asynchronous, active-low; clock clk. Reset values: floor_o = HOME_FLOOR, dir_o = 00, moving_o = 0, door_open_o = 0, pending_o = 0, busy_o = 0, counters = 0, state IDLE, preferred direction = up. Reset mid-operation aborts travel and door immediately, and all pending requests are dropped.
- Request latch:
  - Bits of hall_req_i | car_req_i sampled at edge k are set in pending_o after edge k.
  - The FSM acts on them at edge k+1.
  - Set and clear of the same bit at the same edge: clear wins.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE:
  - pending[floor_o] set → DOOR_OPEN.
  - Otherwise, if there is pending work in the preferred direction, move that way; else in the opposite direction; else remain IDLE.
  - Preferred direction = last travelled direction.
- MOVE_UP / MOVE_DOWN:
  - moving_o = 1; dir_o = 01 or 10.
  - Travel counter runs 0..TRAVEL_CYC-1. On the count==TRAVEL_CYC-1 edge, floor_o is incremented or decremented and the counter is cleared.
  - Same edge decision: if pending[new floor] is set → DOOR_OPEN; otherwise continue.
  - floor_o never leaves 0..N_FLOORS-1. Pending work is always ahead while moving, so no wrap occurs.
- DOOR_OPEN:
  - On entry: door_open_o = 1, moving_o = 0, pending[floor_o] cleared, dwell counter loaded with DOOR_CYC.
  - A new request for floor_o while the door is open clears that bit and restarts the dwell.
  - When dwell expires: if pending ahead in dir_o → move the same direction; else if pending behind → reverse; else IDLE with dir_o = 00.
  - door_open_o drops on the same edge.
- Invariant: door_open_o and moving_o are never both 1.
- Arithmetic:
  - "Ahead up" = any pending bit index > floor_o; "ahead down" = any pending bit index < floor_o. Evaluated with masks of width N_FLOORS.
  - Counters are sized to $clog2(max(TRAVEL_CYC, DOOR_CYC)+1).

Optional Feature:
- Macro ELEV_DOOR_HOLD_EN.
- Defined: adds input door_hold_i (1 bit). While door_hold_i = 1 in DOOR_OPEN, the dwell counter reloads to DOOR_CYC every cycle and the door cannot close. door_hold_i has no effect in other states.
- Undefined: no port; the door always closes DOOR_CYC cycles after entry (or after the last restart by a same-floor request).

Test Plan:
- Reset at floor 0, car_req_i[3] pulse at edge k → MOVE_UP from edge k+1; floor_o = 1, 2, 3 at edges k+4, k+8, k+12; door_open_o = 1 for 6 cycles; pending_o[3] = 0 after edge k+12; IDLE with dir_o = 00 and busy_o = 0 afterwards.
- At floor 0 idle, hall_req_i[5] and car_req_i[2] in the same cycle → stop at 2 (door 6 cycles), continue up to 5, door opens there; no down movement in between.
- Moving up from 0 to 6, hall_req_i[1] at floor 2 → serve 6 first, then dir_o = 10 and travel down to 1; pending_o = 0 at end.
- Idle at floor 4, car_req_i[4] → door opens at edge k+1, floor_o stays 4, moving_o never asserts; a second car_req_i[4] during the door restarts the 6-cycle dwell.
- Assert rst_n = 0 mid-travel between floors 2 and 3 with pending bits 5 and 7 set → all outputs return to reset values asynchronously, pending_o = 0, floor_o = HOME_FLOOR.
- With ELEV_DOOR_HOLD_EN, hold door_hold_i = 1 for 20 cycles in DOOR_OPEN → door_open_o stays 1 throughout and closes 6 cycles after release; without the macro → door closes after 6 cycles.
